decoder3_8_pulse: RTL

DECODER3_8_PULSE -- requirements
Module: decoder3_8_pulse

---
 rtl/decoder3_8_pulse.sv | 122 ++++++++++++
 1 files changed

// File: rtl/decoder3_8_pulse.sv
// 3-to-8 decoder that turns each accepted code into a timed one-hot pulse.
// A pulse lasts PULSE_LEN cycles. It is followed by GAP_LEN forced all-zero
// cycles before the next code can be accepted. Dropping en aborts the
// pulse or gap and returns the block to IDLE.
module decoder3_8_pulse #(
  parameter int PULSE_LEN = 4,  // 1..15
  parameter int GAP_LEN   = 1   // 0..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Counter reload values; the down-counter expires when it reaches zero.
  localparam logic [3:0] PULSE_LOAD = 4'(PULSE_LEN - 1);
  localparam logic [3:0] GAP_LOAD   = (GAP_LEN > 0) ? 4'(GAP_LEN - 1) : 4'd0;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] out_q, out_d;
  logic       out_valid_q, out_valid_d;

  // Binary code to one-hot bit position.
  function automatic logic [7:0] onehot(input logic [2:0] code);
    onehot = 8'd1 << code;
  endfunction

  // Handshake and status come straight from the current state.
  always_comb begin
    in_ready  = (state_q == IDLE) && en;
    busy      = (state_q != IDLE);
    out       = out_q;
    out_valid = out_valid_q;
  end

  // Next-state logic. A low en wins over counter expiry in DRIVE and GAP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (en && in_valid) begin
          state_d     = DRIVE;
          cnt_d       = PULSE_LOAD;
          out_d       = onehot(in_code);
          out_valid_d = 1'b1;
        end else begin
          state_d     = IDLE;
          cnt_d       = 4'd0;
          out_d       = 8'h00;
          out_valid_d = 1'b0;
        end
      end
      DRIVE: begin
        if (!en) begin
          state_d     = IDLE;
          cnt_d       = 4'd0;
          out_d       = 8'h00;
          out_valid_d = 1'b0;
        end else if (cnt_q == 4'd0) begin
          out_d       = 8'h00;
          out_valid_d = 1'b0;
          if (GAP_LEN > 0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      GAP: begin
        if (!en || (cnt_q == 4'd0)) begin
          state_d     = IDLE;
          cnt_d       = 4'd0;
          out_d       = 8'h00;
          out_valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = 4'd0;
        out_d       = 8'h00;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // FSM state, counter and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      out_q       <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
